// File: rtl/wb_arbiter_if.sv
// Bundle of the arbiter's issue, result, write-port and hazard-check signals.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface wb_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32
);
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_long;

    logic                 alu_valid;
    logic [4:0]           alu_rd;
    logic [WIDTH-1:0]     alu_data;

    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [4:0]           lsu_rd;
    logic [WIDTH-1:0]     lsu_data;

    logic                 write_enable;
    logic [4:0]           waddr;
    logic [WIDTH-1:0]     wdata;

    logic [4:0]           chk_rs1;
    logic [4:0]           chk_rs2;
    logic                 hazard;

    logic [REG_COUNT-1:0] busy;

    modport slave (
        input  issue_valid, issue_rd, issue_long,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output write_enable, waddr, wdata,
        input  chk_rs1, chk_rs2,
        output hazard, busy
    );

    modport master (
        output issue_valid, issue_rd, issue_long,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  write_enable, waddr, wdata,
        output chk_rs1, chk_rs2,
        input  hazard, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority over a 2-deep LSU result FIFO,
// feeding one registered register-file write port plus a pending-write scoreboard.
module wb_arbiter #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t               mem_q [2];
    entry_t               mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 write_enable_q, write_enable_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;

    logic                 lsu_ready;
    logic                 push;
    logic                 pop;
    entry_t               head;
    logic                 sel_valid;
    logic [4:0]           sel_rd;
    logic [WIDTH-1:0]     sel_data;
    logic                 hazard;

    // Ready depends on current occupancy only, so a same-cycle pop never frees a slot.
    assign lsu_ready = !rst && (count_q != 2'd2);
    assign push      = bus.lsu_valid && lsu_ready;
    assign pop       = !bus.alu_valid && (count_q != 2'd0);
    assign head      = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sel_valid      = 1'b0;
        sel_rd         = 5'd0;
        sel_data       = '0;

        if (push) begin
            mem_d[wr_ptr_q] = '{rd: bus.lsu_rd, data: bus.lsu_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end

        write_enable_d = sel_valid && (sel_rd != 5'd0);
        waddr_d        = sel_valid ? sel_rd   : waddr_q;
        wdata_d        = sel_valid ? sel_data : wdata_q;
    end

    // A new long-latency issue to the same rd outranks the completing pop.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (bus.issue_valid && bus.issue_long && (32'(bus.issue_rd) == i)) begin
                busy_d[i] = 1'b1;
            end else if (pop && (32'(head.rd) == i)) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (busy_q[i] && ((32'(bus.chk_rs1) == i) || (32'(bus.chk_rs2) == i))) begin
                hazard = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            write_enable_q <= 1'b0;
            waddr_q        <= 5'd0;
            wdata_q        <= '0;
            busy_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            write_enable_q <= write_enable_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.lsu_ready    = lsu_ready;
    assign bus.write_enable = write_enable_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.busy         = busy_q;
    assign bus.hazard       = hazard;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change and outputs are sampled 1ns
// after each rising edge; expected values are hand-derived per scenario.
module tb_wb_arbiter;
    localparam int WIDTH     = 32;
    localparam int REG_COUNT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    wb_arbiter_if #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) bus ();

    wb_arbiter #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.issue_long = 1'b0;
        bus.alu_valid   = 1'b0; bus.alu_rd   = 5'd0; bus.alu_data   = '0;
        bus.lsu_valid   = 1'b0; bus.lsu_rd   = 5'd0; bus.lsu_data   = '0;
        bus.chk_rs1     = 5'd0; bus.chk_rs2  = 5'd0;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [WIDTH-1:0] d);
        bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [WIDTH-1:0] d);
        bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd);
        bus.issue_valid = v; bus.issue_rd = rd; bus.issue_long = v;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_ready_low", 64'(bus.lsu_ready), 64'd0);
        check("rst_we", 64'(bus.write_enable), 64'd0);
        check("rst_waddr", 64'(bus.waddr), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.lsu_ready), 64'd1);

        // ALU only
        alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        alu(1'b0, 5'd0, '0);
        check("alu_we", 64'(bus.write_enable), 64'd1);
        check("alu_waddr", 64'(bus.waddr), 64'd5);
        check("alu_wdata", 64'(bus.wdata), 64'hDEAD_BEEF);
        tick();
        check("alu_we_drop", 64'(bus.write_enable), 64'd0);
        check("alu_waddr_hold", 64'(bus.waddr), 64'd5);
        check("alu_wdata_hold", 64'(bus.wdata), 64'hDEAD_BEEF);

        // Priority: LSU entry waits behind two ALU cycles
        lsu(1'b1, 5'd3, 32'h11);
        tick();
        lsu(1'b0, 5'd0, '0);
        alu(1'b1, 5'd7, 32'h22);
        check("prio_ready_one", 64'(bus.lsu_ready), 64'd1);
        check("prio_c1_we", 64'(bus.write_enable), 64'd0);
        tick();
        check("prio_c2_waddr", 64'(bus.waddr), 64'd7);
        check("prio_c2_wdata", 64'(bus.wdata), 64'h22);
        tick();
        alu(1'b0, 5'd0, '0);
        check("prio_c3_we", 64'(bus.write_enable), 64'd1);
        check("prio_c3_waddr", 64'(bus.waddr), 64'd7);
        tick();
        check("prio_c4_we", 64'(bus.write_enable), 64'd1);
        check("prio_c4_waddr", 64'(bus.waddr), 64'd3);
        check("prio_c4_wdata", 64'(bus.wdata), 64'h11);
        tick();
        check("prio_c5_we", 64'(bus.write_enable), 64'd0);

        // Full FIFO under ALU pressure, then ordered drain
        alu(1'b1, 5'd10, 32'hA0);
        lsu(1'b1, 5'd1, 32'h101);
        tick();
        lsu(1'b1, 5'd2, 32'h202);
        check("full_ready_1", 64'(bus.lsu_ready), 64'd1);
        tick();
        lsu(1'b1, 5'd6, 32'h606);
        check("full_ready_0", 64'(bus.lsu_ready), 64'd0);
        tick();
        check("full_ready_held", 64'(bus.lsu_ready), 64'd0);
        check("full_alu_waddr", 64'(bus.waddr), 64'd10);
        alu(1'b0, 5'd0, '0);
        lsu(1'b0, 5'd0, '0);
        #1;
        check("full_ready_same_pop", 64'(bus.lsu_ready), 64'd0);
        tick();
        check("drain1_waddr", 64'(bus.waddr), 64'd1);
        check("drain1_wdata", 64'(bus.wdata), 64'h101);
        check("drain1_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        check("drain2_we", 64'(bus.write_enable), 64'd1);
        check("drain2_waddr", 64'(bus.waddr), 64'd2);
        check("drain2_wdata", 64'(bus.wdata), 64'h202);
        tick();
        check("drain_no_overflow", 64'(bus.write_enable), 64'd0);

        // Scoreboard set, hazard, clear on pop
        issue(1'b1, 5'd9);
        tick();
        issue(1'b0, 5'd0);
        bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd0;
        #1;
        check("sb_busy9", 64'(bus.busy), 64'h200);
        check("sb_hazard_rs1", 64'(bus.hazard), 64'd1);
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd9;
        #1;
        check("sb_hazard_rs2", 64'(bus.hazard), 64'd1);
        bus.chk_rs2 = 5'd8;
        #1;
        check("sb_no_hazard", 64'(bus.hazard), 64'd0);
        bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd0;
        lsu(1'b1, 5'd9, 32'h99);
        tick();
        lsu(1'b0, 5'd0, '0);
        check("sb_push_keeps", 64'(bus.busy[9]), 64'd1);
        tick();
        check("sb_pop_clears", 64'(bus.busy[9]), 64'd0);
        check("sb_pop_hazard", 64'(bus.hazard), 64'd0);
        check("sb_pop_waddr", 64'(bus.waddr), 64'd9);
        check("sb_pop_wdata", 64'(bus.wdata), 64'h99);
        // Set on the pop edge wins
        issue(1'b1, 5'd9);
        tick();
        issue(1'b0, 5'd0);
        lsu(1'b1, 5'd9, 32'h77);
        tick();
        lsu(1'b0, 5'd0, '0);
        issue(1'b1, 5'd9);
        tick();
        issue(1'b0, 5'd0);
        check("sb_set_wins", 64'(bus.busy[9]), 64'd1);
        check("sb_set_wins_wdata", 64'(bus.wdata), 64'h77);
        alu(1'b1, 5'd9, 32'h5);
        tick();
        alu(1'b0, 5'd0, '0);
        check("sb_alu_no_clear", 64'(bus.busy[9]), 64'd1);

        // x0 is never busy and never written
        issue(1'b1, 5'd0);
        lsu(1'b1, 5'd0, 32'h55);
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0;
        tick();
        issue(1'b0, 5'd0);
        lsu(1'b0, 5'd0, '0);
        check("x0_busy0", 64'(bus.busy[0]), 64'd0);
        check("x0_hazard", 64'(bus.hazard), 64'd0);
        check("x0_we_a", 64'(bus.write_enable), 64'd0);
        tick();
        check("x0_we_pop", 64'(bus.write_enable), 64'd0);
        tick();
        check("x0_we_after", 64'(bus.write_enable), 64'd0);

        // Reset mid-operation
        alu(1'b1, 5'd13, 32'hD);
        issue(1'b1, 5'd4);
        lsu(1'b1, 5'd11, 32'hB);
        tick();
        issue(1'b0, 5'd0);
        lsu(1'b1, 5'd12, 32'hC);
        tick();
        lsu(1'b0, 5'd0, '0);
        check("mid_full", 64'(bus.lsu_ready), 64'd0);
        check("mid_busy4", 64'(bus.busy[4]), 64'd1);
        rst = 1'b1;
        alu(1'b0, 5'd0, '0);
        lsu(1'b1, 5'd14, 32'hE);
        #1;
        check("mid_rst_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        rst = 1'b0;
        lsu(1'b0, 5'd0, '0);
        #1;
        check("mid_we", 64'(bus.write_enable), 64'd0);
        check("mid_waddr", 64'(bus.waddr), 64'd0);
        check("mid_wdata", 64'(bus.wdata), 64'd0);
        check("mid_busy", 64'(bus.busy), 64'd0);
        check("mid_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        check("mid_empty_1", 64'(bus.write_enable), 64'd0);
        tick();
        check("mid_empty_2", 64'(bus.write_enable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
